// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: control inputs, ROM port, decode-side queue output.
// Handshake: the head entry transfers on a rising edge where out_valid && out_ready
// are both high; out_valid never depends on out_ready, and the head holds while
// out_valid=1 && out_ready=0.
interface instruction_fetch_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fetch_enable;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic [DATA_WIDTH-1:0] rom_address;
    logic [DATA_WIDTH-1:0] rom_instruction;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_instruction;
    logic [DATA_WIDTH-1:0] out_pc;
    logic                  out_ready;
    logic                  fault;
    logic [1:0]            state_dbg;

    // Fetch unit side
    modport master (
        input  fetch_enable, redirect_valid, redirect_pc, rom_instruction, out_ready,
        output rom_address, out_valid, out_instruction, out_pc, fault, state_dbg
    );

    // Environment side (ROM, decode, execute)
    modport slave (
        output fetch_enable, redirect_valid, redirect_pc, rom_instruction, out_ready,
        input  rom_address, out_valid, out_instruction, out_pc, fault, state_dbg
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the fetch PC, addresses the combinational ROM and
// captures {pc, instruction} pairs into a 2-entry queue feeding decode.
// Redirects flush the queue; an illegal fetch PC parks the unit in FAULT.
module instruction_fetch_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0
) (
    input logic                      clk,
    input logic                      reset,
    instruction_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-3:0] DEPTH_WORDS = (DATA_WIDTH-2)'(MEMORY_DEPTH);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] q_pc_q [2];
    logic [DATA_WIDTH-1:0] q_pc_d [2];
    logic [DATA_WIDTH-1:0] q_instr_q [2];
    logic [DATA_WIDTH-1:0] q_instr_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;

    logic pc_legal, fetch_active, head_valid, pop, has_space, push, fault_hit;

    // Fetch qualification: legality, space (a same-cycle pop frees a slot), push/pop
    always_comb begin
        pc_legal     = (fetch_pc_q[1:0] == 2'b00) && (fetch_pc_q[DATA_WIDTH-1:2] < DEPTH_WORDS);
        fetch_active = bus.fetch_enable && (state_q != FAULT);
        head_valid   = (count_q != 2'd0);
        pop          = head_valid && bus.out_ready;
        has_space    = (count_q != 2'd2) || pop;
        push         = fetch_active && !bus.redirect_valid && pc_legal && has_space;
        fault_hit    = fetch_active && !bus.redirect_valid && !pc_legal;
    end

    // FSM next state, sticky fault and fetch PC; redirect overrides everything
    always_comb begin
        state_d    = state_q;
        fault_d    = fault_q;
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_valid) begin
            state_d    = bus.fetch_enable ? RUN : IDLE;
            fault_d    = 1'b0;
            fetch_pc_d = bus.redirect_pc;
        end else begin
            if (fault_hit) begin
                state_d = FAULT;
                fault_d = 1'b1;
            end else begin
                case (state_q)
                    IDLE:    if (bus.fetch_enable) state_d = RUN;
                    RUN:     if (!bus.fetch_enable) state_d = IDLE;
                    default: state_d = state_q;
                endcase
            end
            if (push) fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
        end
    end

    // Circular queue update; a redirect drops all entries including a same-cycle pop
    always_comb begin
        q_pc_d    = q_pc_q;
        q_instr_d = q_instr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (bus.redirect_valid) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                q_pc_d[wr_ptr_q]    = fetch_pc_q;
                q_instr_d[wr_ptr_q] = bus.rom_instruction;
                wr_ptr_d            = ~wr_ptr_q;
            end
            if (pop) rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            fault_q    <= 1'b0;
            q_pc_q     <= '{default: '0};
            q_instr_q  <= '{default: '0};
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            fault_q    <= fault_d;
            q_pc_q     <= q_pc_d;
            q_instr_q  <= q_instr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign bus.rom_address     = fetch_pc_q;
    assign bus.out_valid       = head_valid;
    assign bus.out_instruction = head_valid ? q_instr_q[rd_ptr_q] : '0;
    assign bus.out_pc          = head_valid ? q_pc_q[rd_ptr_q] : '0;
    assign bus.fault           = fault_q;
    assign bus.state_dbg       = state_q;
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Sequences the combinational program memory ROM: holds the fetch PC, drives the ROM address, and captures each returned instruction with its PC into a 2-entry queue. The queue feeds decode through a valid/ready handshake. Sits between the ROM and the decode stage, and absorbs decode back-pressure and control-flow redirects from execute.

## Interface
- DATA_WIDTH, 32: address, PC and instruction width.
- MEMORY_DEPTH, 32: ROM depth in words; bounds the legal fetch range.
- RESET_PC, 0: fetch PC after reset; must be word aligned.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_enable  in  1  allows fetching; when low, no new pushes, and the queue still drains.
- redirect_valid  in  1  redirects fetch to redirect_pc and flushes the queue.
- redirect_pc  in  DATA_WIDTH  new fetch PC.
- rom_address  out  DATA_WIDTH  byte address to the ROM; combinationally equals fetch_pc.
- rom_instruction  in  DATA_WIDTH  ROM read data, valid in the same cycle as rom_address.
- out_valid  out  1  queue head holds a valid instruction.
- out_instruction  out  DATA_WIDTH  instruction at the queue head.
- out_pc  out  DATA_WIDTH  PC of out_instruction.
- out_ready  in  1  decode accepts the head; the head pops when out_valid && out_ready.
- fault  out  1  sticky flag: fetch_pc was misaligned or out of range.

## Operation
- State machine: IDLE, RUN, FAULT.
  - IDLE: entered on reset. Goes to RUN on the first cycle with fetch_enable=1.
  - RUN: falls back to IDLE when fetch_enable=0.
  - FAULT: left only by redirect or reset.
- Fetch condition:
  - state is RUN (or fetch_enable=1 in IDLE);
  - no redirect this cycle;
  - fetch_pc is legal;
  - queue count < 2, or count == 2 with a pop in the same cycle.
- When the fetch condition holds, the unit pushes {fetch_pc, rom_instruction} and sets fetch_pc <= fetch_pc + 4. The add wraps modulo 2^DATA_WIDTH.
- fetch_pc is legal when fetch_pc[1:0] == 0 and fetch_pc[DATA_WIDTH-1:2] < MEMORY_DEPTH.
- An illegal fetch_pc in RUN causes no push, sets fault=1 and moves to FAULT. Entries already queued stay and drain normally.
- Redirect (redirect_valid=1) has top priority, in any state:
  - queue cleared (count=0) and fault cleared;
  - fetch_pc <= redirect_pc;
  - state <= RUN if fetch_enable=1, else IDLE;
  - no push in that cycle; any pop in that cycle is discarded with the flush.
- Queue is a 2-entry circular buffer with 1-bit read/write pointers and a 2-bit count.
  - Push and pop in the same cycle leave count unchanged.
  - A pop on empty is impossible, since out_valid=0.
- Output stability: while out_valid=1 and out_ready=0, out_instruction and out_pc hold.
- out_instruction and out_pc are 0 when the queue is empty.

## Timing
- Reset values:
  - fetch_pc=RESET_PC, so rom_address=RESET_PC;
  - queue empty, out_valid=0, out_instruction=0, out_pc=0;
  - fault=0, state=IDLE.
- Reset acts immediately, mid-operation included; the queue contents are lost.
- Latency: an instruction pushed at edge N is visible with out_valid=1 after edge N.
- Throughput: one instruction per cycle with out_ready held high.
- After a redirect at edge N:
  - out_valid=0 after N;
  - the first redirected instruction is pushed at N+1 and visible after N+1.
- With out_ready=0, the queue fills after 2 fetch edges and fetch_pc stalls at the third PC. When out_ready rises, a pop and a push occur on the same edge.
- fault rises on the edge after the illegal PC is presented and stays high until redirect or reset.

## Test plan
- Reset release with fetch_enable=1, out_ready=1, RESET_PC=0, ROM word i = 0x1000+i -> out_pc 0,4,8,... with out_instruction 0x1000,0x1001,... on consecutive cycles; first out_valid one edge after the first fetch.
- out_ready=0 for 5 cycles from the start -> exactly 2 entries queued (PC 0,4), rom_address held at 8, head stable; release out_ready -> PCs 0,4,8,12 delivered in order with no gap or duplicate.
- Redirect to 0x40 while the queue holds 2 entries -> out_valid=0 next cycle; PC 0x40 (word 16) appears one cycle later; no stale PC is delivered.
- Run sequential fetch to the end of MEMORY_DEPTH=32 -> last delivered PC is 0x7C; fault=1 at PC 0x80, no further pushes; then redirect to 0 -> fault=0 and fetch resumes at 0.
- Redirect to 0x6 (misaligned) -> fault=1 and no push. Separately, fetch_enable=0 mid-stream -> the queue drains and fetching resumes from the held PC when fetch_enable returns to 1.
- Assert reset asynchronously mid-cycle with 2 entries queued -> out_valid=0 and fault=0 immediately; rom_address=RESET_PC.
